rock_paper_scissors: RTL and testbench

ROCK_PAPER_SCISSORS -- requirements
Module: rock_paper_scissors

---
 rtl/rps_pkg.sv | 15 +
 rtl/rps_judge.sv | 48 ++++
 rtl/rock_paper_scissors.sv | 60 ++++++
 tb/tb_rock_paper_scissors.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rps_pkg.sv
// rtl/rps_pkg.sv - shared gesture codes and round outcome encoding
package rps_pkg;

  localparam logic [1:0] GEST_ROCK    = 2'b00;
  localparam logic [1:0] GEST_PAPER   = 2'b01;
  localparam logic [1:0] GEST_SCISORS = 2'b10;

  typedef enum logic [1:0] {
    A_WIN = 2'd0,
    B_WIN = 2'd1,
    DRAW  = 2'd2,
    ERROR = 2'd3
  } outcome_e;

endpackage

// File: rtl/rps_judge.sv
// rtl/rps_judge.sv - combinational gesture decode and round outcome flags
module rps_judge
  import rps_pkg::*;
#(
  parameter logic [1:0] ROCK    = GEST_ROCK,
  parameter logic [1:0] PAPER   = GEST_PAPER,
  parameter logic [1:0] SCISORS = GEST_SCISORS
) (
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic       is_A_win,
  output logic       is_B_win,
  output logic       is_draw,
  output logic       is_error,
  output outcome_e   outcome
);

  logic is_A_rock, is_A_paper, is_A_scisors;
  logic is_B_rock, is_B_paper, is_B_scisors;
  logic a_valid, b_valid;

  assign is_A_rock    = (A == ROCK);
  assign is_A_paper   = (A == PAPER);
  assign is_A_scisors = (A == SCISORS);
  assign is_B_rock    = (B == ROCK);
  assign is_B_paper   = (B == PAPER);
  assign is_B_scisors = (B == SCISORS);

  assign a_valid = is_A_rock | is_A_paper | is_A_scisors;
  assign b_valid = is_B_rock | is_B_paper | is_B_scisors;

  // Win terms only fire when both sides decoded, so error excludes the rest.
  assign is_error = ~(a_valid & b_valid);
  assign is_A_win = (is_A_rock & is_B_scisors) | (is_A_paper & is_B_rock) |
                    (is_A_scisors & is_B_paper);
  assign is_B_win = (is_B_rock & is_A_scisors) | (is_B_paper & is_A_rock) |
                    (is_B_scisors & is_A_paper);
  assign is_draw  = (is_A_rock & is_B_rock) | (is_A_paper & is_B_paper) |
                    (is_A_scisors & is_B_scisors);

  always_comb begin
    outcome = ERROR;
    if (is_A_win)      outcome = A_WIN;
    else if (is_B_win) outcome = B_WIN;
    else if (is_draw)  outcome = DRAW;
  end

endmodule

// File: rtl/rock_paper_scissors.sv
// rtl/rock_paper_scissors.sv - round judge with saturating per-outcome tallies
module rock_paper_scissors
  import rps_pkg::*;
#(
  parameter logic [1:0] ROCK    = GEST_ROCK,
  parameter logic [1:0] PAPER   = GEST_PAPER,
  parameter logic [1:0] SCISORS = GEST_SCISORS,
  parameter int         CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       A,
  input  logic [1:0]       B,
  output logic             is_A_win,
  output logic             is_error,
  output logic             is_draw,
  output logic             is_B_win,
  output logic [CNT_W-1:0] a_wins,
  output logic [CNT_W-1:0] b_wins,
  output logic [CNT_W-1:0] draws,
  output logic [CNT_W-1:0] errors
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  outcome_e outcome;

  rps_judge #(
    .ROCK    (ROCK),
    .PAPER   (PAPER),
    .SCISORS (SCISORS)
  ) u_judge (
    .A        (A),
    .B        (B),
    .is_A_win (is_A_win),
    .is_B_win (is_B_win),
    .is_draw  (is_draw),
    .is_error (is_error),
    .outcome  (outcome)
  );

  // Only the tally matching this round moves; a full tally simply holds.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_wins <= '0;
      b_wins <= '0;
      draws  <= '0;
      errors <= '0;
    end else begin
      unique case (outcome)
        A_WIN: if (a_wins != CNT_MAX) a_wins <= a_wins + CNT_ONE;
        B_WIN: if (b_wins != CNT_MAX) b_wins <= b_wins + CNT_ONE;
        DRAW:  if (draws  != CNT_MAX) draws  <= draws  + CNT_ONE;
        ERROR: if (errors != CNT_MAX) errors <= errors + CNT_ONE;
      endcase
    end
  end

endmodule

// File: tb/tb_rock_paper_scissors.sv
// tb/tb_rock_paper_scissors.sv - directed self-checking bench for rock_paper_scissors
`timescale 1ps/1ps
module tb_rock_paper_scissors;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] A = 2'b00, B = 2'b00;
  logic       is_A_win, is_B_win, is_draw, is_error;
  logic [7:0] a_wins, b_wins, draws, errors;

  logic [1:0] A2 = 2'b00, B2 = 2'b00;
  logic       o_A_win, o_B_win, o_draw, o_error;
  logic [7:0] o_a_wins, o_b_wins, o_draws, o_errors;

  int total = 0;
  int bad   = 0;

  // Expected outcome per {B,A}: 0=A win, 1=B win, 2=draw, 3=error.
  int exp_tab [16] = '{2, 0, 1, 3,
                       1, 2, 0, 3,
                       0, 1, 2, 3,
                       3, 3, 3, 3};

  always #50 clk = ~clk;

  rock_paper_scissors dut (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .is_A_win (is_A_win),
    .is_error (is_error),
    .is_draw  (is_draw),
    .is_B_win (is_B_win),
    .a_wins   (a_wins),
    .b_wins   (b_wins),
    .draws    (draws),
    .errors   (errors)
  );

  rock_paper_scissors #(
    .ROCK    (2'b11),
    .PAPER   (2'b10),
    .SCISORS (2'b01),
    .CNT_W   (8)
  ) dut_ovr (
    .clk      (clk),
    .reset    (reset),
    .A        (A2),
    .B        (B2),
    .is_A_win (o_A_win),
    .is_error (o_error),
    .is_draw  (o_draw),
    .is_B_win (o_B_win),
    .a_wins   (o_a_wins),
    .b_wins   (o_b_wins),
    .draws    (o_draws),
    .errors   (o_errors)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags_for(input int code);
    case (code)
      0:       return 4'b1000;
      1:       return 4'b0100;
      2:       return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  initial begin
    #10 reset = 1'b0;
    A = 2'b01; B = 2'b00;
    #190;
    check("tally_a_in_reset", a_wins, 0);
    check("tally_b_in_reset", b_wins, 0);
    check("tally_d_in_reset", draws, 0);
    check("tally_e_in_reset", errors, 0);
    check("comb_in_reset", {is_A_win, is_B_win, is_draw, is_error}, 4'b1000);

    #110;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      {B, A} = 4'(i);
      #1;
      check($sformatf("sweep_%0d", i), {is_A_win, is_B_win, is_draw, is_error},
            flags_for(exp_tab[i]));
      @(posedge clk);
      #1;
    end
    check("sweep_a_wins", a_wins, 3);
    check("sweep_b_wins", b_wins, 3);
    check("sweep_draws", draws, 3);
    check("sweep_errors", errors, 7);

    #40 reset = 1'b0;
    #1;
    check("async_rst_a", a_wins, 0);
    check("async_rst_b", b_wins, 0);
    check("async_rst_d", draws, 0);
    check("async_rst_e", errors, 0);

    A = 2'b10; B = 2'b01;
    #10 reset = 1'b1;
    repeat (254) @(posedge clk);
    #1;
    check("sat_254", a_wins, 254);
    repeat (46) @(posedge clk);
    #1;
    check("sat_hold", a_wins, 255);
    check("sat_b_zero", b_wins, 0);
    check("sat_d_zero", draws, 0);
    check("sat_e_zero", errors, 0);

    A = 2'b10; B = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    check("sat_others_count", draws, 2);
    check("sat_a_still", a_wins, 255);

    A2 = 2'b10; B2 = 2'b11;
    #1;
    check("ovr_a_win", {o_A_win, o_B_win, o_draw, o_error}, 4'b1000);
    A2 = 2'b00; B2 = 2'b11;
    #1;
    check("ovr_error", {o_A_win, o_B_win, o_draw, o_error}, 4'b0001);
    A2 = 2'b01; B2 = 2'b11;
    #1;
    check("ovr_b_win", {o_A_win, o_B_win, o_draw, o_error}, 4'b0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
